// File: rtl/hd_timing_pkg.sv
// Shared constants and types for the beat/timing generator that feeds the hardwired controller.
// Machine cycles W and beat phases T are both one-hot.
package hd_timing_pkg;

    localparam logic [2:0] W1_OH = 3'b001;
    localparam logic [2:0] W2_OH = 3'b010;
    localparam logic [2:0] W3_OH = 3'b100;

    localparam logic [2:0] PH_IDLE = 3'b000;
    localparam logic [2:0] PH_T1   = 3'b001;
    localparam logic [2:0] PH_T2   = 3'b010;
    localparam logic [2:0] PH_T3   = 3'b100;

    typedef enum logic {
        HALT = 1'b0,
        RUN  = 1'b1
    } run_state_e;

    // Machine cycle that follows w at a beat boundary; an illegal w falls back to W1.
    function automatic logic [2:0] next_beat(input logic [2:0] w,
                                             input logic       short_i,
                                             input logic       long_i);
        logic [2:0] nxt;
        case (w)
            W1_OH:   nxt = short_i ? W1_OH : W2_OH;
            W2_OH:   nxt = long_i ? W3_OH : W1_OH;
            default: nxt = W1_OH;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/hd_timing_gen_if.sv
// Signals between the timing generator, the front panel and the hardwired controller.
// master = generator side, slave = controller/panel side.
interface hd_timing_gen_if;
    logic       QD;
    logic       DP;
    logic       SHORT;
    logic       LONG;
    logic       STOP;
    logic       T1;
    logic       T2;
    logic       T3;
    logic [2:0] W;
    logic       RUN;

    modport master (
        input  QD, DP, SHORT, LONG, STOP,
        output T1, T2, T3, W, RUN
    );

    modport slave (
        output QD, DP, SHORT, LONG, STOP,
        input  T1, T2, T3, W, RUN
    );
endinterface

// File: rtl/hd_qd_sync.sv
// Synchronizes the asynchronous QD push-button and emits a one-cycle pulse on its rising edge.
// Flops reset to 1 so a button held through reset release does not register as an edge.
module hd_qd_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic qd,
    output logic qd_rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;

    always_comb begin
        sync_d[0] = qd;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign qd_rise = rise_q;

endmodule

// File: rtl/hd_timing_gen.sv
// Beat generator: rotates T1->T2->T3 while running and steps W at each end of T3,
// honouring SHORT/LONG for sequencing and STOP/DP for halting.
module hd_timing_gen
    import hd_timing_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter bit AUTO_RUN    = 1'b0
) (
    input  logic CLK,
    input  logic CLR,
    hd_timing_gen_if.master bus
);

    logic       qd_rise;
    run_state_e state_q, state_d;
    logic [2:0] phase_q, phase_d;
    logic [2:0] w_q, w_d;

    hd_qd_sync #(.SYNC_STAGES(SYNC_STAGES)) u_qd_sync (
        .clk     (CLK),
        .clr_n   (CLR),
        .qd      (bus.QD),
        .qd_rise (qd_rise)
    );

    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= AUTO_RUN ? RUN : HALT;
            phase_q <= PH_IDLE;
            w_q     <= W1_OH;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            w_q     <= w_d;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        w_d     = w_q;
        case (state_q)
            HALT: begin
                // W is left alone so execution resumes on the beat held during the halt.
                phase_d = PH_IDLE;
                if (qd_rise) begin
                    state_d = RUN;
                    phase_d = PH_T1;
                end
            end
            RUN: begin
                // qd_rise is deliberately ignored here, even on the halting boundary.
                case (phase_q)
                    PH_T1: phase_d = PH_T2;
                    PH_T2: phase_d = PH_T3;
                    PH_T3: begin
                        w_d = next_beat(w_q, bus.SHORT, bus.LONG);
                        if (bus.STOP || bus.DP) begin
                            state_d = HALT;
                            phase_d = PH_IDLE;
                        end else begin
                            phase_d = PH_T1;
                        end
                    end
                    default: phase_d = PH_T1;
                endcase
            end
            default: begin
                state_d = HALT;
                phase_d = PH_IDLE;
            end
        endcase
    end

    assign bus.T1  = phase_q[0];
    assign bus.T2  = phase_q[1];
    assign bus.T3  = phase_q[2];
    assign bus.W   = w_q;
    assign bus.RUN = (state_q == RUN);

endmodule

// File: tb/tb_hd_timing_gen.sv
// Randomized check of hd_timing_gen against a cycle-level beat model (integer W, beat phase
// and a delay-line view of the QD synchronizer), preceded by directed start/step/halt scenarios.
module tb_hd_timing_gen;

    localparam int S = 2;

    logic CLK = 1'b0;
    logic CLR = 1'b0;

    hd_timing_gen_if bus ();

    hd_timing_gen #(.SYNC_STAGES(S), .AUTO_RUN(1'b0)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model state: m_w in 1..3, m_ph 0 (no phase) or 1..3.
    bit m_hist[S+2];
    bit m_rise;
    bit m_run;
    int m_ph;
    int m_w;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < S + 2; i++) m_hist[i] = 1'b1;
        m_rise = 1'b0;
        m_run  = 1'b0;
        m_ph   = 0;
        m_w    = 1;
    endtask

    task automatic check_outputs(input string where);
        logic [2:0] t_obs;
        t_obs = {bus.T3, bus.T2, bus.T1};
        chk({where, "_W"}, 32'(bus.W), 32'(1 << (m_w - 1)));
        chk({where, "_T"}, 32'(t_obs), (m_ph == 0) ? 32'd0 : 32'(1 << (m_ph - 1)));
        chk({where, "_RUN"}, 32'(bus.RUN), 32'(m_run));
        $display("cyc t=%0t clr=%0b qd=%0b W=%03b T=%03b RUN=%0b", $time, CLR, bus.QD, bus.W, t_obs, bus.RUN);
    endtask

    // One clock: the inputs present now are what the DUT samples at the coming edge.
    task automatic tick();
        bit qd, sh, lg, sp, dp, rise_old;
        qd = bus.QD; sh = bus.SHORT; lg = bus.LONG; sp = bus.STOP; dp = bus.DP;
        rise_old = m_rise;
        @(posedge CLK);
        #1;
        if (CLR) begin
            if (!m_run) begin
                if (rise_old) begin
                    m_run = 1'b1;
                    m_ph  = 1;
                end
            end else if (m_ph == 3) begin
                if (m_w == 1)      m_w = sh ? 1 : 2;
                else if (m_w == 2) m_w = lg ? 3 : 1;
                else               m_w = 1;
                if (sp || dp) begin
                    m_run = 1'b0;
                    m_ph  = 0;
                end else begin
                    m_ph = 1;
                end
            end else begin
                m_ph = m_ph + 1;
            end
            for (int i = S + 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = qd;
            m_rise = m_hist[S] & ~m_hist[S+1];
        end
        check_outputs("cyc");
    endtask

    // Asynchronous mid-cycle reset: outputs must drop before the next clock edge.
    task automatic do_clr();
        #2;
        CLR = 1'b0;
        #1;
        model_reset();
        check_outputs("clr");
        tick();
        tick();
        CLR = 1'b1;
    endtask

    task automatic wait_t1(input string tag, output int lat);
        lat = 0;
        while (!bus.T1 && lat < 40) begin
            tick();
            lat++;
        end
        if (!bus.T1) chk({tag, "_timeout"}, 32'(bus.T1), 32'd1);
    endtask

    initial begin
        int lat;
        int run_len;
        logic [2:0] beat_w;
        logic [2:0] prev_w;

        bus.QD = 1'b1; bus.DP = 1'b0; bus.SHORT = 1'b0; bus.LONG = 1'b0; bus.STOP = 1'b0;
        model_reset();
        repeat (3) tick();
        CLR = 1'b1;

        // Button held through reset release: no start.
        repeat (20) tick();
        chk("idle_RUN", 32'(bus.RUN), 32'd0);

        // Start latency: edge visible after S+1 clocks, T1 one clock later.
        bus.QD = 1'b0;
        repeat (S + 2) tick();
        bus.QD = 1'b1;
        wait_t1("start", lat);
        chk("t1_lat", 32'(lat), 32'(S + 2));
        chk("start_W", 32'(bus.W), 32'd1);

        // SHORT in W1 repeats W1.
        bus.SHORT = 1'b1;
        repeat (12) tick();
        chk("short_W", 32'(bus.W), 32'd1);
        bus.SHORT = 1'b0;

        // LONG sequence then plain sequence.
        bus.LONG = 1'b1;
        repeat (12) tick();
        bus.LONG = 1'b0;
        repeat (12) tick();

        // STOP only at W2 T3, with a QD pulse around the halt.
        bus.LONG = 1'b1;
        run_len = 0;
        while (!(bus.W == 3'b010 && bus.T2) && run_len < 20) begin
            tick();
            run_len++;
        end
        tick();
        bus.STOP = 1'b1;
        bus.QD = 1'b0;
        tick();
        bus.STOP = 1'b0;
        chk("halt_RUN", 32'(bus.RUN), 32'd0);
        chk("halt_W", 32'(bus.W), 32'd4);
        repeat (6) tick();
        bus.QD = 1'b1;
        wait_t1("resume", lat);
        chk("resume_W", 32'(bus.W), 32'd4);

        // Single step: each QD pulse yields exactly one beat.
        bus.DP = 1'b1;
        while (bus.RUN && run_len < 60) begin
            tick();
            run_len++;
        end
        prev_w = bus.W;
        for (int p = 0; p < 3; p++) begin
            bus.QD = 1'b0;
            repeat (S + 2) tick();
            bus.QD = 1'b1;
            wait_t1("dp", lat);
            beat_w = bus.W;
            chk("dp_beat_W", 32'(beat_w), 32'(prev_w));
            run_len = 0;
            while (bus.RUN && run_len < 20) begin
                tick();
                run_len++;
            end
            chk("dp_beat_len", 32'(run_len), 32'd3);
            prev_w = (beat_w == 3'b001) ? 3'b010 : (beat_w == 3'b010) ? 3'b100 : 3'b001;
        end
        bus.DP = 1'b0;

        // Mid-beat reset while running in W2 T2.
        bus.QD = 1'b0;
        repeat (S + 2) tick();
        bus.QD = 1'b1;
        run_len = 0;
        while (!(bus.W == 3'b010 && bus.T2) && run_len < 40) begin
            tick();
            run_len++;
        end
        do_clr();

        // Random traffic including glitchy controller inputs and stray QD edges.
        for (int c = 0; c < 3000; c++) begin
            bus.SHORT = ($urandom_range(0, 2) == 0);
            bus.LONG  = ($urandom_range(0, 1) == 0);
            bus.STOP  = ($urandom_range(0, 7) == 0);
            bus.DP    = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 5) == 0) bus.QD = ~bus.QD;
            if ($urandom_range(0, 499) == 0) do_clr();
            else tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
